// File: rtl/muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_if
// Bundles the pipeline-side and divider-side signals of the multiply/divide
// controller.
//   master : pipeline/divider environment (drives op_*, a, b, flush, hold_in,
//            div_result, div_ready; observes stall, HILO and divider controls)
//   slave  : muldiv_ctrl itself
// Signals:
//   op_valid, op_code[1:0], a[31:0], b[31:0]  E-stage mul/div instruction
//   flush, hold_in                            E-stage flush / downstream stall
//   stall_out                                 pipeline freeze request
//   hilo_we, hilo_wdata[63:0]                 {HI,LO} write port
//   div_start, div_signed, div_annul          divider control
//   div_opa[31:0], div_opb[31:0]              divider operands
//   div_result[63:0] {rem,quot}, div_ready    divider response
// -----------------------------------------------------------------------------
interface muldiv_ctrl_if;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hold_in;
  logic        stall_out;
  logic        hilo_we;
  logic [63:0] hilo_wdata;
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic [63:0] div_result;
  logic        div_ready;

  modport master (
    output op_valid, op_code, a, b, flush, hold_in, div_result, div_ready,
    input  stall_out, hilo_we, hilo_wdata, div_start, div_signed, div_annul,
           div_opa, div_opb
  );

  modport slave (
    input  op_valid, op_code, a, b, flush, hold_in, div_result, div_ready,
    output stall_out, hilo_we, hilo_wdata, div_start, div_signed, div_annul,
           div_opa, div_opb
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Sequences MULT/MULTU/DIV/DIVU for the E stage: latches operands, computes the
// product in one cycle or drives an external iterative divider, freezes the
// pipeline while busy and writes {HI,LO} once the result is ready.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : muldiv_ctrl_if.slave (see interface for the signal list)
// Optional feature:
//   DIV_ZERO_FAST_EN : when defined, DIV/DIVU with b == 0 skips the divider and
//                      completes with {a, 32'hFFFF_FFFF} after a 1-cycle stall.
// -----------------------------------------------------------------------------
module muldiv_ctrl (
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        signed_q;        // 1 for MULT/DIV, 0 for MULTU/DIVU
  logic [31:0] a_q, b_q;
  logic [63:0] result_q, result_d;
  logic [63:0] last_wdata_q;    // value most recently written to HILO

  logic        issue_s;
  logic        div_zero_fast_s;
  logic [63:0] mul_a_s, mul_b_s, product_s;
  logic        stall_s, hilo_we_s, div_start_s, div_signed_s, div_annul_s;

  assign issue_s = (state_q == ST_IDLE) && bus.op_valid && !bus.flush;

`ifdef DIV_ZERO_FAST_EN
  assign div_zero_fast_s = bus.op_code[1] && (bus.b == 32'd0);
`else
  assign div_zero_fast_s = 1'b0;
`endif

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned multiplication.
  assign mul_a_s   = {{32{a_q[31] & signed_q}}, a_q};
  assign mul_b_s   = {{32{b_q[31] & signed_q}}, b_q};
  assign product_s = mul_a_s * mul_b_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything, including div_ready
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.op_valid) begin
            if (!bus.op_code[1]) begin
              state_d = ST_MUL;
            end else if (div_zero_fast_s) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_DIV_RUN;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: state_d = ST_DONE;
        ST_DIV_RUN: begin
          if (bus.div_ready) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DIV_RUN;
          end
        end
        ST_DONE: begin
          if (bus.hold_in) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    stall_s      = 1'b0;
    hilo_we_s    = 1'b0;
    div_start_s  = 1'b0;
    div_signed_s = 1'b0;
    div_annul_s  = 1'b0;
    case (state_q)
      ST_IDLE: stall_s = issue_s;
      ST_MUL:  stall_s = 1'b1;
      ST_DIV_RUN: begin
        stall_s      = 1'b1;
        div_signed_s = signed_q;
        div_start_s  = !bus.flush;
        div_annul_s  = bus.flush;
      end
      ST_DONE: hilo_we_s = !bus.hold_in && !bus.flush;
      default: stall_s = 1'b0;
    endcase
  end

  // Result register next value: product, divider response or fast div-by-zero
  always_comb begin
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_s && div_zero_fast_s) begin
          result_d = {bus.a, 32'hFFFF_FFFF};
        end else begin
          result_d = result_q;
        end
      end
      ST_MUL: begin
        if (!bus.flush) begin
          result_d = product_s;
        end else begin
          result_d = result_q;
        end
      end
      ST_DIV_RUN: begin
        if (bus.div_ready && !bus.flush) begin
          result_d = bus.div_result;
        end else begin
          result_d = result_q;
        end
      end
      default: result_d = result_q;
    endcase
  end

  // Operand latch, result register and last-written HILO value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signed_q     <= 1'b0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      result_q     <= 64'd0;
      last_wdata_q <= 64'd0;
    end else begin
      if (issue_s) begin
        signed_q <= !bus.op_code[0];
        a_q      <= bus.a;
        b_q      <= bus.b;
      end
      result_q <= result_d;
      if (hilo_we_s) begin
        last_wdata_q <= result_q;
      end
    end
  end

  assign bus.stall_out  = stall_s;
  assign bus.hilo_we    = hilo_we_s;
  assign bus.hilo_wdata = hilo_we_s ? result_q : last_wdata_q;
  assign bus.div_start  = div_start_s;
  assign bus.div_signed = div_signed_s;
  assign bus.div_annul  = div_annul_s;
  assign bus.div_opa    = a_q;
  assign bus.div_opb    = b_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed scoreboard bench for muldiv_ctrl. Stimulus pushes the hand-computed
// HILO value expected for each operation; an independent monitor pops and
// compares on every hilo_we. A small divider model answers div_start after a
// programmable latency with a bench-supplied result.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;
  logic clk;
  logic rst;
  muldiv_ctrl_if bus();

  muldiv_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  logic [63:0] exp_q[$];

  logic        model_ready;
  logic        stray_ready;
  logic [63:0] div_resp;
  int          div_lat;

  logic        seen_start;
  logic        seen_signed;
  logic [31:0] seen_opa;
  logic [31:0] seen_opb;

  assign bus.div_ready  = model_ready | stray_ready;
  assign bus.div_result = div_resp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Divider model: raise div_ready for one cycle after div_lat cycles of div_start
  initial begin
    int cnt;
    cnt = 0;
    model_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (model_ready) begin
        model_ready = 1'b0;
        cnt = 0;
      end else if (bus.div_start) begin
        cnt++;
        if (cnt >= div_lat) model_ready = 1'b1;
      end else begin
        cnt = 0;
      end
    end
  end

  // Record what the DUT presents to the divider
  initial begin
    forever begin
      @(negedge clk);
      if (bus.div_start === 1'b1) begin
        seen_start  = 1'b1;
        seen_signed = bus.div_signed;
        seen_opa    = bus.div_opa;
        seen_opb    = bus.div_opb;
      end
    end
  end

  // Scoreboard monitor: every HILO write must match the oldest expectation
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (bus.hilo_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL hilo_unexpected_write actual=%h expected=no_write", bus.hilo_wdata);
        end else begin
          e = exp_q.pop_front();
          if (bus.hilo_wdata !== e) begin
            errors++;
            $display("FAIL hilo_wdata actual=%h expected=%h", bus.hilo_wdata, e);
          end
        end
      end
    end
  end

  // Issue one op and count stall cycles (issue cycle included); optionally keep
  // op_valid high with different operands during the cycle after issue.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit linger, output int n);
    @(posedge clk); #2;
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.a        = a;
    bus.b        = b;
    @(negedge clk);
    n = (bus.stall_out === 1'b1) ? 1 : 0;
    @(posedge clk); #2;
    if (linger) begin
      bus.a = 32'h1234_5678;
      bus.b = 32'h0000_0009;
      @(negedge clk);
      if (bus.stall_out === 1'b1) n++;
      @(posedge clk); #2;
    end
    bus.op_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.stall_out !== 1'b1) break;
      n++;
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk); #2;
    bus.op_valid = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    stray_ready = 1'b0;
    div_resp = 64'd0;
    div_lat = 1000;
    seen_start = 1'b0;
    seen_signed = 1'b0;
    seen_opa = 32'd0;
    seen_opb = 32'd0;
    bus.op_valid = 1'b0;
    bus.op_code  = 2'b00;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    bus.flush    = 1'b0;
    bus.hold_in  = 1'b0;
    rst = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall_out", {63'd0, bus.stall_out}, 64'd0);
    check("rst_hilo_we", {63'd0, bus.hilo_we}, 64'd0);
    check("rst_div_start", {63'd0, bus.div_start}, 64'd0);
    check("rst_div_signed", {63'd0, bus.div_signed}, 64'd0);
    check("rst_div_annul", {63'd0, bus.div_annul}, 64'd0);
    check("rst_hilo_wdata", bus.hilo_wdata, 64'd0);
    check("rst_div_opa", {32'd0, bus.div_opa}, 64'd0);
    check("rst_div_opb", {32'd0, bus.div_opb}, 64'd0);
    @(posedge clk); #2;
    rst = 1'b1;

    // MULT -2 * 3
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, n);
    check("mult_stall_cycles", n, 64'd2);
    @(posedge clk);
    @(negedge clk);
    check("idle_hilo_we", {63'd0, bus.hilo_we}, 64'd0);
    check("idle_hilo_hold", bus.hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFA);

    // MULTU, op_valid left high during MUL must not re-latch
    exp_q.push_back(64'h0000_0001_FFFF_FFFE);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b1, n);
    check("multu_stall_cycles", n, 64'd2);

    // DIV -7 / 2 with a 33-cycle divider
    div_lat = 33;
    div_resp = 64'hFFFF_FFFF_FFFF_FFFD;
    seen_start = 1'b0;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, n);
    check("div_stall_cycles", n, 64'd34);
    check("div_start_seen", {63'd0, seen_start}, 64'd1);
    check("div_signed", {63'd0, seen_signed}, 64'd1);
    check("div_opa", {32'd0, seen_opa}, 64'h0000_0000_FFFF_FFF9);
    check("div_opb", {32'd0, seen_opb}, 64'd2);

    // DIVU flushed in its 10th divider cycle
    div_lat = 50;
    start_op(2'b11, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2 bus.flush = 1'b1;
    @(negedge clk);
    check("flush_div_annul", {63'd0, bus.div_annul}, 64'd1);
    check("flush_div_start", {63'd0, bus.div_start}, 64'd0);
    check("flush_divu_signed", {63'd0, bus.div_signed}, 64'd0);
    check("flush_hilo_we", {63'd0, bus.hilo_we}, 64'd0);
    @(posedge clk); #2;
    bus.flush = 1'b0;
    @(negedge clk);
    check("post_flush_stall", {63'd0, bus.stall_out}, 64'd0);
    check("post_flush_annul", {63'd0, bus.div_annul}, 64'd0);
    check("post_flush_start", {63'd0, bus.div_start}, 64'd0);

    // DONE held for 3 cycles by hold_in
    bus.hold_in = 1'b1;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, n);
    check("hold_mult_stall", n, 64'd2);
    check("hold_we_c1", {63'd0, bus.hilo_we}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_we_c23", {63'd0, bus.hilo_we}, 64'd0);
    end
    @(posedge clk); #2;
    bus.hold_in = 1'b0;
    @(negedge clk);
    check("hold_release_we", {63'd0, bus.hilo_we}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("hold_after_we", {63'd0, bus.hilo_we}, 64'd0);

    // Flush in the same cycle the divider answers: no write
    div_lat = 5;
    div_resp = 64'hDEAD_BEEF_0BAD_F00D;
    start_op(2'b10, 32'd40, 32'd3);
    repeat (4) @(posedge clk);
    #2 bus.flush = 1'b1;
    @(negedge clk);
    check("race_div_annul", {63'd0, bus.div_annul}, 64'd1);
    check("race_hilo_we", {63'd0, bus.hilo_we}, 64'd0);
    @(posedge clk); #2;
    bus.flush = 1'b0;
    @(negedge clk);
    check("race_idle_stall", {63'd0, bus.stall_out}, 64'd0);
    check("race_idle_we", {63'd0, bus.hilo_we}, 64'd0);

    // Stray div_ready while idle is ignored
    stray_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("stray_stall", {63'd0, bus.stall_out}, 64'd0);
    check("stray_we", {63'd0, bus.hilo_we}, 64'd0);
    stray_ready = 1'b0;

    // Reset during a division
    div_lat = 60;
    start_op(2'b10, 32'd99, 32'd4);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_stall", {63'd0, bus.stall_out}, 64'd0);
    check("midrst_div_start", {63'd0, bus.div_start}, 64'd0);
    check("midrst_hilo_wdata", bus.hilo_wdata, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    exp_q.push_back(64'h0000_0000_0000_000C);
    run_op(2'b00, 32'd3, 32'd4, 1'b0, n);
    check("post_rst_stall", n, 64'd2);

    // Divide by zero
    seen_start = 1'b0;
`ifdef DIV_ZERO_FAST_EN
    exp_q.push_back(64'h0000_0005_FFFF_FFFF);
    run_op(2'b10, 32'd5, 32'd0, 1'b0, n);
    check("div0_stall", n, 64'd1);
    check("div0_no_start", {63'd0, seen_start}, 64'd0);
`else
    div_lat = 3;
    div_resp = 64'h0000_0005_FFFF_FFFF;
    exp_q.push_back(64'h0000_0005_FFFF_FFFF);
    run_op(2'b10, 32'd5, 32'd0, 1'b0, n);
    check("div0_stall", n, 64'd4);
    check("div0_start_seen", {63'd0, seen_start}, 64'd1);
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: op_valid  in  1  E-stage multiply/divide instruction present.
REQ-004 SHALL have: op_code  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have: a, b  in  32 each  rs/rt operands.
REQ-006 SHALL have: flush  in  1  exception/flush of E stage.
REQ-007 SHALL have: hold_in  in  1  downstream stall; E stage may not advance.
REQ-008 SHALL have: stall_out  out  1  freeze pipeline while operation runs.
REQ-009 SHALL have: hilo_we  out  1 and hilo_wdata  out  64  {HI,LO} write.
REQ-010 SHALL have: div_start, div_signed, div_annul  out  1 each; div_opa, div_opb  out  32; div_result  in  64 {rem,quot}; div_ready  in  1.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV_RUN, DONE.
REQ-012 IDLE, op_valid=1, flush=0: SHALL latch a, b, op_code; MULT/MULTU -> MUL; DIV/DIVU -> DIV_RUN.
REQ-013 stall_out SHALL be 1 combinationally in the IDLE issue cycle and throughout MUL and DIV_RUN; 0 in IDLE-without-issue and DONE.
REQ-014 MUL: SHALL register 64-bit product (signed for MULT, zero-extended for MULTU) and go DONE next cycle; total stall 2 cycles.
REQ-015 DIV_RUN: div_start=1 and div_opa/div_opb = latched operands, div_signed=1 for DIV, 0 for DIVU; held stable until div_ready.
REQ-016 div_ready=1 in DIV_RUN: SHALL capture div_result into result register, drop div_start, go DONE.
REQ-017 DONE, hold_in=0: hilo_we=1 for exactly that cycle, hilo_wdata = result register, next state IDLE.
REQ-018 DONE, hold_in=1: SHALL remain in DONE, hilo_we=0, result unchanged.
REQ-019 flush=1 in any state: next state IDLE, hilo_we=0 that cycle; in DIV_RUN div_annul=1 for one cycle and div_start=0.
REQ-020 flush and div_ready in same cycle: flush SHALL win; no HILO write.
REQ-021 op_valid in non-IDLE states SHALL be ignored (no re-latch).
REQ-022 div_ready outside DIV_RUN SHALL be ignored.
REQ-023 hilo_wdata SHALL hold last value when hilo_we=0.

Reset
REQ-024 rst=0 SHALL asynchronously force IDLE; stall_out, hilo_we, div_start, div_signed, div_annul = 0; hilo_wdata, div_opa, div_opb, result register = 0.
REQ-025 Reset asserted mid-division SHALL abandon operation with no HILO write; first op after release behaves as from IDLE.

Configuration
REQ-026 Macro DIV_ZERO_FAST_EN defined: DIV/DIVU with b=0 in IDLE SHALL go directly to DONE (1-cycle stall), result {a, 32'hFFFF_FFFF}, div_start never asserted.
REQ-027 DIV_ZERO_FAST_EN undefined: b=0 SHALL follow normal DIV_RUN path; result is whatever divider returns.

Verification
REQ-028 MULT a=32'hFFFF_FFFE, b=3 -> stall 2 cycles, then hilo_we=1, hilo_wdata=64'hFFFF_FFFF_FFFF_FFFA.
REQ-029 MULTU a=32'hFFFF_FFFF, b=2 -> hilo_wdata=64'h0000_0001_FFFF_FFFE after 2-cycle stall.
REQ-030 DIV a=-7, b=2, divider returns after 33 cycles -> div_signed=1, stall until ready, hilo_wdata={32'hFFFF_FFFF,32'hFFFF_FFFD}.
REQ-031 DIVU in progress, flush at cycle 10 -> div_annul pulse, IDLE next cycle, no hilo_we, stall_out=0.
REQ-032 DONE with hold_in=1 for 3 cycles -> hilo_we stays 0, then single-cycle hilo_we when hold_in drops.
REQ-033 With DIV_ZERO_FAST_EN, DIV a=5, b=0 -> 1-cycle stall, div_start=0, hilo_wdata=64'h0000_0005_FFFF_FFFF.
